// File: rtl/pipe_ctrl_pkg.sv
// Shared encodings for the pipeline control unit: trap FSM states and
// per-stage hold patterns.
package pipe_ctrl_pkg;

  // Trap-entry FSM states
  typedef enum logic [1:0] {
    CTRL_IDLE   = 2'd0,
    CTRL_WAIT   = 2'd1,
    CTRL_TAKE   = 2'd2,
    CTRL_SETTLE = 2'd3
  } ctrl_state_e;

  // hold_ena_o patterns, bit order {ID/EX, IF/ID, PC}
  localparam logic [2:0] HOLD_NONE    = 3'b000;
  localparam logic [2:0] HOLD_LOADUSE = 3'b011;
  localparam logic [2:0] HOLD_ALL     = 3'b111;

  localparam logic JUMP_ENABLE = 1'b1;
  localparam logic HOLD_ENABLE = 1'b1;

endpackage

// File: rtl/pipe_ctrl_irq_fsm.sv
// Interrupt-entry FSM: arms on a request, waits out multi-cycle stalls,
// takes the trap for one cycle, then ignores the request for one cycle.
// Owns the state register, the latched trap vector and the EPC.
module pipe_ctrl_irq_fsm
  import pipe_ctrl_pkg::*;
#(
  parameter int ADDR_W = 32
) (
  input  logic              clk_100MHz,
  input  logic              rst,
  input  logic              irq_req_i,
  input  logic [ADDR_W-1:0] irq_vec_i,
  input  logic              stall_i,
  input  logic              jump_req_ex_i,
  input  logic [ADDR_W-1:0] jump_addr_ex_i,
  input  logic [ADDR_W-1:0] ex_pc_i,
  output ctrl_state_e       state_o,
  output logic [ADDR_W-1:0] vec_o,
  output logic [ADDR_W-1:0] epc_o
);

  ctrl_state_e       state_q, state_d;
  logic [ADDR_W-1:0] vec_q, vec_d;
  logic [ADDR_W-1:0] epc_q, epc_d;

  // Next-state, vector latch and EPC capture
  always_comb begin
    state_d = state_q;
    vec_d   = vec_q;
    epc_d   = epc_q;
    case (state_q)
      CTRL_IDLE: begin
        if (irq_req_i) begin
          vec_d   = irq_vec_i;
          state_d = stall_i ? CTRL_WAIT : CTRL_TAKE;
        end
      end
      CTRL_WAIT: begin
        // a dropped request does not cancel; the latched vector is used
        if (!stall_i) state_d = CTRL_TAKE;
      end
      CTRL_TAKE: begin
        // a branch resolving in the trap cycle is squashed, so resume at its target
        epc_d   = jump_req_ex_i ? jump_addr_ex_i : ex_pc_i;
        state_d = CTRL_SETTLE;
      end
      CTRL_SETTLE: state_d = CTRL_IDLE;
      default:     state_d = CTRL_IDLE;
    endcase
  end

  // State, vector and EPC registers with synchronous reset
  always_ff @(posedge clk_100MHz) begin
    if (rst) begin
      state_q <= CTRL_IDLE;
      vec_q   <= '0;
      epc_q   <= '0;
    end else begin
      state_q <= state_d;
      vec_q   <= vec_d;
      epc_q   <= epc_d;
    end
  end

  assign state_o = state_q;
  assign vec_o   = vec_q;
  assign epc_o   = epc_q;

endmodule

// File: rtl/pipe_ctrl.sv
// Central pipeline control: merges hold and redirect requests into the PC
// jump/hold interface and per-stage hold/flush lines.
// Optional feature macro: PIPE_CTRL_PERF_CNT_EN adds saturating stall and
// flush counters.
module pipe_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int CNT_W  = 32
) (
  input  logic              clk_100MHz,
  input  logic              rst,
  input  logic              hold_id_i,
  input  logic              hold_ex_i,
  input  logic              hold_bus_i,
  input  logic              jump_req_ex_i,
  input  logic [ADDR_W-1:0] jump_addr_ex_i,
  input  logic [ADDR_W-1:0] ex_pc_i,
  input  logic              irq_req_i,
  input  logic [ADDR_W-1:0] irq_vec_i,
  output logic              jump_ena_o,
  output logic [ADDR_W-1:0] jump_addr_o,
  output logic [2:0]        hold_ena_o,
  output logic              flush_ifid_o,
  output logic              flush_idex_o,
  output logic              irq_ack_o,
`ifdef PIPE_CTRL_PERF_CNT_EN
  output logic [CNT_W-1:0]  stall_cnt_o,
  output logic [CNT_W-1:0]  flush_cnt_o,
`endif
  output logic [ADDR_W-1:0] epc_o
);

  ctrl_state_e       state;
  logic [ADDR_W-1:0] vec;
  logic              stall;

  assign stall = hold_ex_i | hold_bus_i;

  pipe_ctrl_irq_fsm #(.ADDR_W(ADDR_W)) u_irq_fsm (
    .clk_100MHz     (clk_100MHz),
    .rst            (rst),
    .irq_req_i      (irq_req_i),
    .irq_vec_i      (irq_vec_i),
    .stall_i        (stall),
    .jump_req_ex_i  (jump_req_ex_i),
    .jump_addr_ex_i (jump_addr_ex_i),
    .ex_pc_i        (ex_pc_i),
    .state_o        (state),
    .vec_o          (vec),
    .epc_o          (epc_o)
  );

  // Priority mux: trap states override the normal stall > branch > load-use order
  always_comb begin
    jump_ena_o   = 1'b0;
    jump_addr_o  = '0;
    hold_ena_o   = HOLD_NONE;
    flush_ifid_o = 1'b0;
    flush_idex_o = 1'b0;
    irq_ack_o    = 1'b0;
    if (!rst) begin
      if (state == CTRL_TAKE) begin
        jump_ena_o   = JUMP_ENABLE;
        jump_addr_o  = vec;
        flush_ifid_o = 1'b1;
        flush_idex_o = 1'b1;
        irq_ack_o    = 1'b1;
      end else if (state == CTRL_WAIT || (state == CTRL_IDLE && irq_req_i)) begin
        // freeze everything so the instruction in EX survives until the trap
        hold_ena_o = HOLD_ALL;
      end else if (stall) begin
        // EX keeps its jump request up until the stall releases
        hold_ena_o = HOLD_ALL;
      end else if (jump_req_ex_i) begin
        // branch squashes any load-use instruction, so it wins over hold_id_i
        jump_ena_o   = JUMP_ENABLE;
        jump_addr_o  = jump_addr_ex_i;
        flush_ifid_o = 1'b1;
        flush_idex_o = 1'b1;
      end else if (hold_id_i) begin
        hold_ena_o   = HOLD_LOADUSE;
        flush_idex_o = 1'b1;
      end
    end
  end

`ifdef PIPE_CTRL_PERF_CNT_EN
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
  logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;

  // Saturating event counters
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    if (hold_ena_o[0] && stall_cnt_q != {CNT_W{1'b1}}) stall_cnt_d = stall_cnt_q + 1'b1;
    if (flush_ifid_o && flush_cnt_q != {CNT_W{1'b1}}) flush_cnt_d = flush_cnt_q + 1'b1;
  end

  // Counter registers with synchronous reset
  always_ff @(posedge clk_100MHz) begin
    if (rst) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign stall_cnt_o = stall_cnt_q;
  assign flush_cnt_o = flush_cnt_q;
`endif

endmodule

// File: tb/tb_pipe_ctrl.sv
// Scoreboard bench for pipe_ctrl: directed test-plan sequences followed by
// randomized traffic, checked against a behavioural trap/priority model.
module tb_pipe_ctrl;

  logic        clk_100MHz = 1'b0;
  logic        rst, hold_id_i, hold_ex_i, hold_bus_i, jump_req_ex_i, irq_req_i;
  logic [31:0] jump_addr_ex_i, ex_pc_i, irq_vec_i;
  logic        jump_ena_o, flush_ifid_o, flush_idex_o, irq_ack_o;
  logic [31:0] jump_addr_o, epc_o;
  logic [2:0]  hold_ena_o;
`ifdef PIPE_CTRL_PERF_CNT_EN
  logic [31:0] stall_cnt_o, flush_cnt_o;
  logic [3:0]  stall_cnt4, flush_cnt4;
  logic        j2, fi2, fe2, ack2;
  logic [31:0] ja2, epc2;
  logic [2:0]  h2;
`endif

  always #5 clk_100MHz = ~clk_100MHz;

  pipe_ctrl #(.ADDR_W(32), .CNT_W(32)) dut (
    .clk_100MHz(clk_100MHz), .rst(rst), .hold_id_i(hold_id_i), .hold_ex_i(hold_ex_i),
    .hold_bus_i(hold_bus_i), .jump_req_ex_i(jump_req_ex_i), .jump_addr_ex_i(jump_addr_ex_i),
    .ex_pc_i(ex_pc_i), .irq_req_i(irq_req_i), .irq_vec_i(irq_vec_i),
    .jump_ena_o(jump_ena_o), .jump_addr_o(jump_addr_o), .hold_ena_o(hold_ena_o),
    .flush_ifid_o(flush_ifid_o), .flush_idex_o(flush_idex_o), .irq_ack_o(irq_ack_o),
`ifdef PIPE_CTRL_PERF_CNT_EN
    .stall_cnt_o(stall_cnt_o), .flush_cnt_o(flush_cnt_o),
`endif
    .epc_o(epc_o));

`ifdef PIPE_CTRL_PERF_CNT_EN
  pipe_ctrl #(.ADDR_W(32), .CNT_W(4)) dut4 (
    .clk_100MHz(clk_100MHz), .rst(rst), .hold_id_i(hold_id_i), .hold_ex_i(hold_ex_i),
    .hold_bus_i(hold_bus_i), .jump_req_ex_i(jump_req_ex_i), .jump_addr_ex_i(jump_addr_ex_i),
    .ex_pc_i(ex_pc_i), .irq_req_i(irq_req_i), .irq_vec_i(irq_vec_i),
    .jump_ena_o(j2), .jump_addr_o(ja2), .hold_ena_o(h2),
    .flush_ifid_o(fi2), .flush_idex_o(fe2), .irq_ack_o(ack2),
    .stall_cnt_o(stall_cnt4), .flush_cnt_o(flush_cnt4), .epc_o(epc2));
`endif

  typedef struct {
    logic        je;
    logic [31:0] ja;
    logic [2:0]  hold;
    logic        fi, fe, ack;
    logic [31:0] epc;
    logic [31:0] sc, fc;
    logic [3:0]  sc4, fc4;
  } exp_t;

  exp_t exp_q[$];
  int   n_cmp = 0;
  int   n_err = 0;

  // Reference model: a latched trap is pending until no stall, then taken for
  // one cycle, followed by one cooldown cycle where requests are ignored.
  logic        m_pend, m_take, m_cool;
  logic [31:0] m_vec, m_epc, m_sc, m_fc;
  logic [3:0]  m_sc4, m_fc4;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] want);
    n_cmp++;
    if (act !== want) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, want, $time);
    end
  endtask

  // Monitor: the DUT presents a full output set every cycle
  always @(negedge clk_100MHz) begin
    if (exp_q.size() > 0) begin
      exp_t e;
      e = exp_q.pop_front();
      check("jump_ena",    {31'b0, jump_ena_o},   {31'b0, e.je});
      check("jump_addr",   jump_addr_o,           e.ja);
      check("hold_ena",    {29'b0, hold_ena_o},   {29'b0, e.hold});
      check("flush_ifid",  {31'b0, flush_ifid_o}, {31'b0, e.fi});
      check("flush_idex",  {31'b0, flush_idex_o}, {31'b0, e.fe});
      check("irq_ack",     {31'b0, irq_ack_o},    {31'b0, e.ack});
      check("epc",         epc_o,                 e.epc);
`ifdef PIPE_CTRL_PERF_CNT_EN
      check("stall_cnt",   stall_cnt_o,           e.sc);
      check("flush_cnt",   flush_cnt_o,           e.fc);
      check("stall_cnt4",  {28'b0, stall_cnt4},   {28'b0, e.sc4});
      check("flush_cnt4",  {28'b0, flush_cnt4},   {28'b0, e.fc4});
`endif
    end
  end

  // Drive one cycle of inputs, predict the outputs and advance the model
  task automatic cyc(input logic r, input logic hid, input logic hex, input logic hbus,
                     input logic jr, input logic [31:0] ja, input logic [31:0] pc,
                     input logic irq, input logic [31:0] vec);
    exp_t e;
    logic stall;
    @(posedge clk_100MHz);
    #1;
    rst = r; hold_id_i = hid; hold_ex_i = hex; hold_bus_i = hbus;
    jump_req_ex_i = jr; jump_addr_ex_i = ja; ex_pc_i = pc;
    irq_req_i = irq; irq_vec_i = vec;
    stall = hex | hbus;
    e.je = 0; e.ja = 0; e.hold = 3'b000; e.fi = 0; e.fe = 0; e.ack = 0;
    e.epc = m_epc; e.sc = m_sc; e.fc = m_fc; e.sc4 = m_sc4; e.fc4 = m_fc4;
    if (r) begin
      m_pend = 0; m_take = 0; m_cool = 0; m_vec = 0; m_epc = 0;
      m_sc = 0; m_fc = 0; m_sc4 = 0; m_fc4 = 0;
    end else begin
      if (m_take) begin
        e.je = 1; e.ja = m_vec; e.fi = 1; e.fe = 1; e.ack = 1;
        m_epc = jr ? ja : pc;
        m_take = 0; m_cool = 1;
      end else if (m_pend) begin
        e.hold = 3'b111;
        if (!stall) begin m_pend = 0; m_take = 1; end
      end else if (!m_cool && irq) begin
        e.hold = 3'b111;
        m_vec = vec;
        if (stall) m_pend = 1; else m_take = 1;
      end else begin
        m_cool = 0;
        if (stall) e.hold = 3'b111;
        else if (jr) begin e.je = 1; e.ja = ja; e.fi = 1; e.fe = 1; end
        else if (hid) begin e.hold = 3'b011; e.fe = 1; end
      end
      if (e.hold[0]) begin
        if (m_sc != 32'hFFFF_FFFF) m_sc = m_sc + 1;
        if (m_sc4 != 4'hF) m_sc4 = m_sc4 + 1;
      end
      if (e.fi) begin
        if (m_fc != 32'hFFFF_FFFF) m_fc = m_fc + 1;
        if (m_fc4 != 4'hF) m_fc4 = m_fc4 + 1;
      end
    end
    exp_q.push_back(e);
  endtask

  initial begin
    rst = 1; hold_id_i = 0; hold_ex_i = 0; hold_bus_i = 0; jump_req_ex_i = 0;
    jump_addr_ex_i = 0; ex_pc_i = 0; irq_req_i = 1; irq_vec_i = 0;
    m_pend = 0; m_take = 0; m_cool = 0; m_vec = 0; m_epc = 0;
    m_sc = 0; m_fc = 0; m_sc4 = 0; m_fc4 = 0;
    @(posedge clk_100MHz);

    // reset with a pending interrupt request
    for (int i = 0; i < 3; i++) cyc(1, 0, 0, 0, 0, 0, 32'h10, 1, 32'h40);
    cyc(0, 0, 0, 0, 0, 0, 32'h10, 0, 0);
    cyc(0, 0, 0, 0, 0, 0, 32'h14, 0, 0);

    // load-use, then load-use overridden by a branch
    cyc(0, 1, 0, 0, 0, 0, 32'h18, 0, 0);
    cyc(0, 1, 0, 0, 1, 32'h80, 32'h1C, 0, 0);
    cyc(0, 0, 0, 0, 0, 0, 32'h80, 0, 0);

    // divide stall holding back a taken branch
    for (int i = 0; i < 5; i++) cyc(0, 0, 1, 0, 1, 32'hC0, 32'h84, 0, 0);
    cyc(0, 0, 0, 0, 1, 32'hC0, 32'h84, 0, 0);

    // interrupt during divide, request dropped while waiting
    for (int i = 0; i < 4; i++) cyc(0, 0, 1, 0, 0, 0, 32'h3C, (i < 2), 32'h100);
    for (int i = 0; i < 3; i++) cyc(0, 0, 0, 0, 0, 0, 32'h3C, 0, 0);

    // trap coincides with a branch; request still high during cooldown
    cyc(0, 0, 0, 0, 0, 0, 32'h50, 1, 32'h100);
    cyc(0, 0, 0, 0, 1, 32'h200, 32'h54, 1, 32'h100);
    cyc(0, 0, 0, 0, 0, 0, 32'h100, 1, 32'h100);
    cyc(0, 0, 0, 0, 0, 0, 32'h104, 0, 0);

    // reset in the middle of a waiting trap
    cyc(0, 0, 1, 0, 0, 0, 32'h60, 1, 32'h180);
    cyc(1, 0, 1, 0, 0, 0, 32'h60, 0, 0);
    cyc(0, 0, 0, 0, 0, 0, 32'h60, 0, 0);
    cyc(0, 0, 0, 0, 0, 0, 32'h64, 0, 0);

    // long stall to saturate the narrow counter
    for (int i = 0; i < 20; i++) cyc(0, 0, 0, 1, 0, 0, 32'h68, 0, 0);

    // randomized traffic
    for (int i = 0; i < 3000; i++)
      cyc(($urandom_range(0, 299) == 0), ($urandom_range(0, 4) == 0),
          ($urandom_range(0, 7) == 0), ($urandom_range(0, 9) == 0),
          ($urandom_range(0, 3) == 0), {$urandom_range(0, 32'h3FFF), 2'b00},
          {$urandom_range(0, 32'h3FFF), 2'b00}, ($urandom_range(0, 11) == 0),
          {$urandom_range(0, 32'hFF), 4'h0});

    @(negedge clk_100MHz);
    #1;
    if (exp_q.size() != 0) begin
      n_cmp++; n_err++;
      $display("FAIL drain: %0d expected entries left, want 0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/pipe_ctrl.md
Name: pipe_ctrl

Overview:
- Central pipeline control unit for the 5-stage core.
- Merges hold requests from ID, EX and the instruction bus, and redirect requests from the EX branch unit and the interrupt controller.
- Drives the single jump/hold interface of the PC register plus the per-stage hold and flush lines.
- Contains the interrupt-entry FSM, which waits out multi-cycle stalls before redirecting to the trap vector and capturing the EPC.

Parameters:
- ADDR_W, 32: instruction address width; matches `INST_ADDR.
- CNT_W, 32: width of the performance counters (used only with the optional feature).

Ports:
- clk_100MHz  in  1  core clock
- rst  in  1  synchronous reset, active-high
- hold_id_i  in  1  load-use hazard detected in ID
- hold_ex_i  in  1  multi-cycle EX operation (div) busy
- hold_bus_i  in  1  instruction or data bus wait
- jump_req_ex_i  in  1  branch/jump resolved taken in EX
- jump_addr_ex_i  in  ADDR_W  branch target
- ex_pc_i  in  ADDR_W  PC of the instruction currently in EX
- irq_req_i  in  1  level interrupt request from CLINT
- irq_vec_i  in  ADDR_W  trap vector address
- jump_ena_o  out  1  to PC jump_ena_i
- jump_addr_o  out  ADDR_W  to PC jump_addr_i
- hold_ena_o  out  3  {ID/EX, IF/ID, PC} hold; bit0 drives PC hold_ena_i
- flush_ifid_o  out  1  insert bubble into IF/ID
- flush_idex_o  out  1  insert bubble into ID/EX
- irq_ack_o  out  1  one-cycle pulse; trap taken
- epc_o  out  ADDR_W  registered exception return address

Behaviour:
- Interface: one clock; reset is synchronous and active-high.
- All outputs are combinational from inputs and state (zero latency), except epc_o and the FSM state, which are registered.
- Reset state, held while rst=1:
  - FSM=IDLE, epc_o=0, vec_q=0.
  - All control outputs are 0.
  - rst mid-trap returns to IDLE with no ack.
- Hold priority while no trap is active:
  - hold_ex_i | hold_bus_i -> hold_ena_o=3'b111, no flush, jump suppressed. EX keeps jump_req_ex_i asserted until the hold releases.
  - Otherwise jump_req_ex_i -> jump_ena_o=1, jump_addr_o=jump_addr_ex_i, both flushes=1, hold_ena_o=0. The branch overrides hold_id_i because the load-use instruction is squashed.
  - Otherwise hold_id_i -> hold_ena_o=3'b011, flush_idex_o=1.
  - Otherwise all outputs 0. The PC increments by 4.
- FSM states: IDLE, WAIT, TAKE, SETTLE.
  - IDLE: when irq_req_i=1, latch vec_q<=irq_vec_i. In this arm cycle, force hold_ena_o=3'b111 and suppress the jump so the EX contents are preserved. Next state is WAIT if hold_ex_i|hold_bus_i, else TAKE.
  - WAIT: drive hold_ena_o=3'b111 and suppress jumps. Go to TAKE in the first cycle both holds are low.
  - TAKE (exactly 1 cycle):
    - jump_ena_o=1, jump_addr_o=vec_q, both flushes=1, hold_ena_o=0, irq_ack_o=1.
    - epc_o<=jump_req_ex_i ? jump_addr_ex_i : ex_pc_i. The trap beats a simultaneous branch; the EPC is the branch target.
  - SETTLE: ignore irq_req_i for 1 cycle while CLINT drops the request. Normal hold/jump rules apply. Then go to IDLE.
- irq_req_i falling during WAIT does not cancel the trap; the latched vector is taken.
- jump_addr_o=0 whenever jump_ena_o=0.

Optional Feature:
- Macro: PIPE_CTRL_PERF_CNT_EN.
- When defined:
  - Adds outputs stall_cnt_o[CNT_W] and flush_cnt_o[CNT_W], both reset to 0.
  - stall_cnt_o increments in every cycle where hold_ena_o[0]=1.
  - flush_cnt_o increments in every cycle where flush_ifid_o=1.
  - Both counters saturate at all-ones (no wrap).
- When undefined: the ports and logic are absent; behaviour is otherwise identical.

Decomposition:
- Add to the shared define.v:
  - FSM state encodings CTRL_IDLE/WAIT/TAKE/SETTLE (2 bits).
  - HOLD_NONE=3'b000, HOLD_LOADUSE=3'b011, HOLD_ALL=3'b111.
  - Reuse the existing `INST_ADDR, `JUMP_ENABLE and `HOLD_ENABLE.
- Sub-module: one natural split, pipe_ctrl_irq_fsm, which holds the state register, vec_q and epc_o.
- The priority mux stays in the top module.

Test Plan:
- Reset: rst=1 for 3 cycles with irq_req_i=1 -> all outputs 0, epc_o=0; no ack after release until the first IDLE cycle.
- Load-use: hold_id_i=1 for 1 cycle -> hold_ena_o=3'b011, flush_idex_o=1. Adding jump_req_ex_i=1 with addr 0x80 -> jump_ena_o=1, jump_addr_o=0x80, hold_ena_o=0, both flushes=1.
- Div stall with branch: hold_ex_i=1 for 5 cycles while jump_req_ex_i=1 -> hold_ena_o=3'b111 and jump_ena_o=0 throughout; jump_ena_o=1 in the cycle hold_ex_i drops.
- Irq during div: irq_req_i=1, irq_vec_i=0x100 while hold_ex_i=1 for 4 cycles -> WAIT, then TAKE in the first clear cycle: jump_addr_o=0x100, irq_ack_o pulses once, epc_o=ex_pc_i (e.g. 0x3C).
- Trap vs branch: TAKE coincides with jump_req_ex_i=1, addr 0x200 -> jump_addr_o=vec 0x100, epc_o=0x200. irq_req_i still high in SETTLE -> no second ack.
- PIPE_CTRL_PERF_CNT_EN: 7 stall cycles and 2 flushes -> stall_cnt_o=7, flush_cnt_o=2. With CNT_W=4 and 20 stall cycles -> stall_cnt_o=15.
